// File: rtl/bcdcnt2s_if.sv
// bcdcnt2s_if: control inputs and digit/scan outputs of the two-digit BCD counter.
interface bcdcnt2s_if;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] din1;
    logic [3:0] din2;
    logic [3:0] bcd1;
    logic [3:0] bcd2;
    logic       sel;
    logic [1:0] an;
    logic       blank;
    logic       tc;
    modport master(output en, up, load, din1, din2, input bcd1, bcd2, sel, an, blank, tc);
    modport slave(input en, up, load, din1, din2, output bcd1, bcd2, sel, an, blank, tc);
endinterface

// File: rtl/bcdcnt2s.sv
// bcdcnt2s: two-digit BCD up/down counter with prescaled tick, load, terminal count and display scan.
// Define BCDCNT_BLANK_ZERO_EN to blank a leading-zero tens digit.
module bcdcnt2s #(
    parameter int DIVTICK = 50000,
    parameter int DIVSCAN = 1000
) (
    input logic       clk,
    input logic       rst,
    bcdcnt2s_if.slave s
);
    localparam int PW = DIVTICK > 1 ? $clog2(DIVTICK) : 1;
    localparam int SW = DIVSCAN > 1 ? $clog2(DIVSCAN) : 1;
    localparam logic [PW-1:0] PC_MAX = PW'(DIVTICK - 1);
    localparam logic [SW-1:0] SC_MAX = SW'(DIVSCAN - 1);
    logic [PW-1:0] pc_q, pc_d;
    logic [SW-1:0] sc_q, sc_d;
    logic [3:0]    bcd1_q, bcd1_d, bcd2_q, bcd2_d;
    logic          sel_q, sel_d, tc_q, tc_d;
    logic [1:0]    an_q, an_d;
    logic          tick;
    always_comb begin
        tick   = s.en && pc_q == PC_MAX;
        pc_d   = tick ? '0 : pc_q + PW'(s.en);
        sc_d   = sc_q == SC_MAX ? '0 : sc_q + SW'(1);
        sel_d  = sel_q ^ (sc_q == SC_MAX);
        an_d   = sel_d ? 2'b01 : 2'b10;
        bcd1_d = bcd1_q;
        bcd2_d = bcd2_q;
        tc_d   = 1'b0;
        // load consumes a coincident tick without counting or raising tc
        if (s.load) begin
            bcd1_d = s.din1 > 4'd9 ? 4'd9 : s.din1;
            bcd2_d = s.din2 > 4'd9 ? 4'd9 : s.din2;
        end else if (tick && s.up) begin
            bcd1_d = bcd1_q == 4'd9 ? 4'd0 : bcd1_q + 4'd1;
            bcd2_d = bcd1_q != 4'd9 ? bcd2_q : bcd2_q == 4'd9 ? 4'd0 : bcd2_q + 4'd1;
            tc_d   = bcd1_q == 4'd9 && bcd2_q == 4'd9;
        end else if (tick) begin
            bcd1_d = bcd1_q == 4'd0 ? 4'd9 : bcd1_q - 4'd1;
            bcd2_d = bcd1_q != 4'd0 ? bcd2_q : bcd2_q == 4'd0 ? 4'd9 : bcd2_q - 4'd1;
            tc_d   = bcd1_q == 4'd0 && bcd2_q == 4'd0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q   <= '0;
            sc_q   <= '0;
            bcd1_q <= 4'd0;
            bcd2_q <= 4'd0;
            sel_q  <= 1'b0;
            an_q   <= 2'b10;
            tc_q   <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            sc_q   <= sc_d;
            bcd1_q <= bcd1_d;
            bcd2_q <= bcd2_d;
            sel_q  <= sel_d;
            an_q   <= an_d;
            tc_q   <= tc_d;
        end
    end
    assign s.bcd1 = bcd1_q;
    assign s.bcd2 = bcd2_q;
    assign s.sel  = sel_q;
    assign s.an   = an_q;
    assign s.tc   = tc_q;
`ifdef BCDCNT_BLANK_ZERO_EN
    logic blank_q, blank_d;
    assign blank_d = sel_d && bcd2_d == 4'd0;
    always_ff @(posedge clk) begin
        if (rst) blank_q <= 1'b0;
        else blank_q <= blank_d;
    end
    assign s.blank = blank_q;
`else
    assign s.blank = 1'b0;
`endif
endmodule

// File: tb/tb_bcdcnt2s.sv
// tb_bcdcnt2s: randomized and directed stimulus against a decimal-value reference model via a scoreboard queue.
module tb_bcdcnt2s;
    localparam int DT = 4;
    localparam int DS = 3;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    bcdcnt2s_if bus();
    bcdcnt2s #(.DIVTICK(DT), .DIVSCAN(DS)) dut (.clk(clk), .rst(rst), .s(bus.slave));
    typedef struct packed {
        logic [3:0] b1;
        logic [3:0] b2;
        logic       sel;
        logic [1:0] an;
        logic       tc;
        logic       blank;
    } exp_t;
    exp_t q[$];
    int checks = 0;
    int failures = 0;
    int val = 0;
    int ecnt = 0;
    int scnt = 0;
    int cyc = 0;
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask
    task automatic step(input logic r, input logic e, input logic u, input logic l, input int d1, input int d2);
        exp_t x;
        bit tk;
        @(negedge clk);
        rst = r;
        bus.en = e;
        bus.up = u;
        bus.load = l;
        bus.din1 = 4'(d1);
        bus.din2 = 4'(d2);
        x.tc = 1'b0;
        if (r) begin
            val = 0;
            ecnt = 0;
            scnt = 0;
        end else begin
            tk = e && (ecnt % DT == DT - 1);
            if (e) ecnt++;
            scnt++;
            if (l) val = (d2 > 9 ? 9 : d2) * 10 + (d1 > 9 ? 9 : d1);
            else if (tk && u) begin
                x.tc = val == 99;
                val = (val + 1) % 100;
            end else if (tk) begin
                x.tc = val == 0;
                val = (val + 99) % 100;
            end
        end
        x.b1 = 4'(val % 10);
        x.b2 = 4'(val / 10);
        x.sel = ((scnt / DS) % 2) == 1;
        x.an = x.sel ? 2'b01 : 2'b10;
`ifdef BCDCNT_BLANK_ZERO_EN
        x.blank = x.sel && val < 10;
`else
        x.blank = 1'b0;
`endif
        q.push_back(x);
    endtask
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("bcd1", int'(bus.bcd1), int'(x.b1));
                chk("bcd2", int'(bus.bcd2), int'(x.b2));
                chk("sel", int'(bus.sel), int'(x.sel));
                chk("an", int'(bus.an), int'(x.an));
                chk("tc", int'(bus.tc), int'(x.tc));
                chk("blank", int'(bus.blank), int'(x.blank));
            end
        end
    end
    initial begin
        int w;
        repeat (2) step(1, 0, 0, 0, 0, 0);
        repeat (8) step(0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 9, 9);
        repeat (9) step(0, 1, 1, 0, 0, 0);
        step(0, 1, 0, 1, 0, 1);
        repeat (4) step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 1, 0, 0);
        repeat (5) step(0, 1, 0, 0, 0, 0);
        repeat (2) step(0, 1, 1, 0, 0, 0);
        step(0, 1, 1, 1, 12, 15);
        repeat (2) step(0, 1, 1, 0, 0, 0);
        repeat (10) step(0, 0, 1, 0, 0, 0);
        repeat (6) step(0, 1, 1, 0, 0, 0);
        step(0, 0, 1, 1, 5, 0);
        repeat (12) step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 1, 5, 1);
        repeat (12) step(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 299) == 0) step(1, 0, 0, 0, 0, 0);
            else if ($urandom_range(0, 29) == 0)
                step(0, 1'($urandom), 1'($urandom), 1, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            else
                step(0, $urandom_range(0, 9) != 0, $urandom_range(0, 15) != 0, 0, 0, 0);
        end
        w = 0;
        while (q.size() > 0 && w < 10) begin
            @(posedge clk);
            w++;
        end
        #2;
        checks++;
        if (q.size() > 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
